// File: rtl/id_decode_pipe.sv
// id_decode_pipe
// Decode stage with a built-in ID/EX output register. Decodes an RV32I subset
// (OP, OP-IMM, LUI, AUIPC, LOAD, STORE, JAL) and reads the register file
// combinationally. It builds ALU operands and control, and inserts bubbles for
// load-use hazards. Valid/ready handshakes are used on both sides.
//
// Optional feature: define ID_FWD_EN to add an execute-stage forwarding port.
// A forwarded value replaces register file data for rs1/rs2 on an address match.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   in_valid_i / in_ready_o      upstream handshake (IF/ID register)
//   in_pc_i, in_inst_i           instruction PC and word
//   flush_i                      kill held and incoming instruction
//   reg{1,2}_raddr_o             rs1/rs2 addresses, combinational from in_inst_i
//   reg{1,2}_rdata_i             register file data, same cycle
//   ex_fwd_{we,waddr,wdata}_i    forwarding port (ID_FWD_EN only)
//   out_valid_o / out_ready_i    downstream handshake (execute stage)
//   out_pc_o, op_a_o, op_b_o     PC and ALU operands
//   st_data_o                    store data
//   reg_waddr_o, reg_we_o        destination register and write enable
//   mem_re_o, mem_we_o           load / store flags
//   illegal_o                    undecodable instruction
//   alu_ctrl_o                   ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6
//                                SRA=7 OR=8 AND=9 PASSB=10
module id_decode_pipe #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [XLEN-1:0]    in_pc_i,
    input  logic [31:0]        in_inst_i,
    input  logic               flush_i,
    output logic [RADDR_W-1:0] reg1_raddr_o,
    output logic [RADDR_W-1:0] reg2_raddr_o,
    input  logic [XLEN-1:0]    reg1_rdata_i,
    input  logic [XLEN-1:0]    reg2_rdata_i,
`ifdef ID_FWD_EN
    input  logic               ex_fwd_we_i,
    input  logic [RADDR_W-1:0] ex_fwd_waddr_i,
    input  logic [XLEN-1:0]    ex_fwd_wdata_i,
`endif
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [XLEN-1:0]    out_pc_o,
    output logic [XLEN-1:0]    op_a_o,
    output logic [XLEN-1:0]    op_b_o,
    output logic [XLEN-1:0]    st_data_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic               reg_we_o,
    output logic               mem_re_o,
    output logic               mem_we_o,
    output logic               illegal_o,
    output logic [4:0]         alu_ctrl_o
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;

    localparam logic [0:0] LD_NONE   = 1'b0;
    localparam logic [0:0] LD_SHADOW = 1'b1;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [RADDR_W-1:0] rd, rs1, rs2;
    logic [XLEN-1:0]    imm_i, imm_s, imm_u, shamt;

    assign opcode = in_inst_i[6:0];
    assign funct3 = in_inst_i[14:12];
    assign funct7 = in_inst_i[31:25];
    assign rd     = RADDR_W'(in_inst_i[11:7]);
    assign rs1    = RADDR_W'(in_inst_i[19:15]);
    assign rs2    = RADDR_W'(in_inst_i[24:20]);
    assign imm_i  = XLEN'($signed(in_inst_i[31:20]));
    assign imm_s  = XLEN'($signed({in_inst_i[31:25], in_inst_i[11:7]}));
    assign imm_u  = XLEN'($signed({in_inst_i[31:12], 12'b0}));
    assign shamt  = XLEN'(in_inst_i[24:20]);

    assign reg1_raddr_o = rs1;
    assign reg2_raddr_o = rs2;

    // ------------------------------------------------------------------
    // Operand sources (optionally bypassed from execute)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rs1_val, rs2_val;

`ifdef ID_FWD_EN
    logic fwd_ok;
    assign fwd_ok  = ex_fwd_we_i & (ex_fwd_waddr_i != '0);
    assign rs1_val = (fwd_ok && ex_fwd_waddr_i == rs1) ? ex_fwd_wdata_i : reg1_rdata_i;
    assign rs2_val = (fwd_ok && ex_fwd_waddr_i == rs2) ? ex_fwd_wdata_i : reg2_rdata_i;
`else
    assign rs1_val = reg1_rdata_i;
    assign rs2_val = reg2_rdata_i;
`endif

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [XLEN-1:0] op_a_d, op_b_d, st_d;
    logic            we_d, re_d, wm_d, ill_d, use1_d, use2_d;
    logic [4:0]      alu_d;

    always_comb begin
        op_a_d = '0;
        op_b_d = '0;
        st_d   = '0;
        we_d   = 1'b0;
        re_d   = 1'b0;
        wm_d   = 1'b0;
        ill_d  = 1'b0;
        use1_d = 1'b0;
        use2_d = 1'b0;
        alu_d  = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'h00 || funct7 == 7'h20) begin
                    use1_d = 1'b1;
                    use2_d = 1'b1;
                    op_a_d = rs1_val;
                    op_b_d = rs2_val;
                    we_d   = 1'b1;
                    case (funct3)
                        3'b000:  alu_d = funct7[5] ? ALU_SUB : ALU_ADD;
                        3'b001:  alu_d = ALU_SLL;
                        3'b010:  alu_d = ALU_SLT;
                        3'b011:  alu_d = ALU_SLTU;
                        3'b100:  alu_d = ALU_XOR;
                        3'b101:  alu_d = funct7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  alu_d = ALU_OR;
                        default: alu_d = ALU_AND;
                    endcase
                end else begin
                    ill_d = 1'b1;
                end
            end
            OPC_OPIMM: begin
                use1_d = 1'b1;
                op_a_d = rs1_val;
                // Shifts carry shamt in the imm field; bit 30 only picks SRA.
                op_b_d = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt : imm_i;
                we_d   = 1'b1;
                case (funct3)
                    3'b000:  alu_d = ALU_ADD;
                    3'b001:  alu_d = ALU_SLL;
                    3'b010:  alu_d = ALU_SLT;
                    3'b011:  alu_d = ALU_SLTU;
                    3'b100:  alu_d = ALU_XOR;
                    3'b101:  alu_d = in_inst_i[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_d = ALU_OR;
                    default: alu_d = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                op_b_d = imm_u;
                alu_d  = ALU_PASSB;
                we_d   = 1'b1;
            end
            OPC_AUIPC: begin
                op_a_d = in_pc_i;
                op_b_d = imm_u;
                we_d   = 1'b1;
            end
            OPC_LOAD: begin
                use1_d = 1'b1;
                op_a_d = rs1_val;
                op_b_d = imm_i;
                re_d   = 1'b1;
                we_d   = 1'b1;
            end
            OPC_STORE: begin
                use1_d = 1'b1;
                use2_d = 1'b1;
                op_a_d = rs1_val;
                op_b_d = imm_s;
                st_d   = rs2_val;
                wm_d   = 1'b1;
            end
            OPC_JAL: begin
                op_a_d = in_pc_i;
                op_b_d = XLEN'(4);
                we_d   = 1'b1;
            end
            default: ill_d = 1'b1;
        endcase
        if (rd == '0) we_d = 1'b0;
    end

    // ------------------------------------------------------------------
    // Output register and load-use tracking
    // ------------------------------------------------------------------
    logic               out_valid_q;
    logic [XLEN-1:0]    pc_q, op_a_q, op_b_q, st_q;
    logic [RADDR_W-1:0] waddr_q;
    logic               we_q, re_q, wm_q, ill_q;
    logic [4:0]         alu_q;
    logic [0:0]         state_q, state_d;
    logic [RADDR_W-1:0] shadow_rd_q, shadow_rd_d;

    logic ld_held, ld_leave, hazard, accept;

    // A load with a real destination sitting in the output register.
    assign ld_held  = out_valid_q & re_q & (waddr_q != '0);
    assign ld_leave = ld_held & out_ready_i;

    function automatic logic pending(input logic [RADDR_W-1:0] r,
                                     input logic ld_h, input logic [RADDR_W-1:0] held_rd,
                                     input logic shadow, input logic [RADDR_W-1:0] sh_rd);
        return (r != '0) && ((ld_h && r == held_rd) || (shadow && r == sh_rd));
    endfunction

    assign hazard = (use1_d & pending(rs1, ld_held, waddr_q, state_q == LD_SHADOW, shadow_rd_q)) |
                    (use2_d & pending(rs2, ld_held, waddr_q, state_q == LD_SHADOW, shadow_rd_q));

    assign in_ready_o = !hazard && !flush_i && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i & in_ready_o;

    // The shadow covers the cycle after a load leaves, while its data is
    // still in flight in execute. A load leaving during a shadow cycle
    // re-arms it with the new rd.
    always_comb begin
        state_d     = LD_NONE;
        shadow_rd_d = shadow_rd_q;
        if (!flush_i && ld_leave) begin
            state_d     = LD_SHADOW;
            shadow_rd_d = waddr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            st_q        <= '0;
            waddr_q     <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            wm_q        <= 1'b0;
            ill_q       <= 1'b0;
            alu_q       <= ALU_ADD;
            state_q     <= LD_NONE;
            shadow_rd_q <= '0;
        end else begin
            state_q     <= state_d;
            shadow_rd_q <= shadow_rd_d;
            if (flush_i) begin
                out_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                pc_q        <= in_pc_i;
                op_a_q      <= op_a_d;
                op_b_q      <= op_b_d;
                st_q        <= st_d;
                waddr_q     <= rd;
                we_q        <= we_d;
                re_q        <= re_d;
                wm_q        <= wm_d;
                ill_q       <= ill_d;
                alu_q       <= alu_d;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_pc_o    = pc_q;
    assign op_a_o      = op_a_q;
    assign op_b_o      = op_b_q;
    assign st_data_o   = st_q;
    assign reg_waddr_o = waddr_q;
    assign reg_we_o    = we_q;
    assign mem_re_o    = re_q;
    assign mem_we_o    = wm_q;
    assign illegal_o   = ill_q;
    assign alu_ctrl_o  = alu_q;

endmodule

// File: tb/tb_id_decode_pipe.sv
// Testbench for id_decode_pipe: directed scenarios followed by randomized
// traffic, all compared against a cycle-level reference model.
module tb_id_decode_pipe;
    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid_i = 1'b0, flush_i = 1'b0, out_ready_i = 1'b0;
    logic [XLEN-1:0] in_pc_i = '0;
    logic [31:0]     in_inst_i = '0;
    logic [RW-1:0]   reg1_raddr_o, reg2_raddr_o, reg_waddr_o;
    logic [XLEN-1:0] reg1_rdata_i, reg2_rdata_i;
    logic            in_ready_o, out_valid_o, reg_we_o, mem_re_o, mem_we_o, illegal_o;
    logic [XLEN-1:0] out_pc_o, op_a_o, op_b_o, st_data_o;
    logic [4:0]      alu_ctrl_o;
    logic [31:0]     rf [32];
`ifdef ID_FWD_EN
    logic            fwd_we = 1'b0;
    logic [RW-1:0]   fwd_addr = '0;
    logic [XLEN-1:0] fwd_data = '0;
`endif

    always #5 clk = ~clk;

    assign reg1_rdata_i = rf[reg1_raddr_o];
    assign reg2_rdata_i = rf[reg2_raddr_o];

    id_decode_pipe #(.XLEN(XLEN), .RADDR_W(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_pc_i(in_pc_i), .in_inst_i(in_inst_i), .flush_i(flush_i),
        .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
        .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
`ifdef ID_FWD_EN
        .ex_fwd_we_i(fwd_we), .ex_fwd_waddr_i(fwd_addr), .ex_fwd_wdata_i(fwd_data),
`endif
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .op_a_o(op_a_o), .op_b_o(op_b_o), .st_data_o(st_data_o),
        .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .mem_re_o(mem_re_o),
        .mem_we_o(mem_we_o), .illegal_o(illegal_o), .alu_ctrl_o(alu_ctrl_o)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc, a, b, st;
        logic [4:0]  rd, alu;
        logic        we, re, wm, ill;
    } op_t;

    logic        m_vld = 1'b0;
    op_t         m_op;
    int          cyc = 0;
    int          ld_cyc = -10;   // cycle in which the last load was consumed
    logic [4:0]  ld_rd = '0;
    logic        obs_rdy;

    function automatic logic [31:0] rsv(input logic [4:0] r);
`ifdef ID_FWD_EN
        if (fwd_we && fwd_addr != 0 && fwd_addr == r) return fwd_data;
`endif
        return rf[r];
    endfunction

    function automatic op_t ref_dec(input logic [31:0] inst, input logic [31:0] pc);
        op_t o;
        int  alu_base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int  f3 = int'(inst[14:12]);
        int  imm_i = int'($signed(inst[31:20]));
        int  imm_s = int'($signed({inst[31:25], inst[11:7]}));
        logic [4:0] rs1 = inst[19:15];
        logic [4:0] rs2 = inst[24:20];
        o = '{pc: pc, a: 0, b: 0, st: 0, rd: inst[11:7], alu: 0, we: 0, re: 0, wm: 0, ill: 0};
        case (inst[6:0])
            7'h33: if (inst[31:25] == 7'h00 || inst[31:25] == 7'h20) begin
                o.a = rsv(rs1); o.b = rsv(rs2); o.we = 1;
                o.alu = 5'(alu_base[f3] + ((inst[30] && (f3 == 0 || f3 == 5)) ? 1 : 0));
            end else o.ill = 1;
            7'h13: begin
                o.a = rsv(rs1); o.we = 1;
                o.b = (f3 == 1 || f3 == 5) ? 32'(inst[24:20]) : 32'(imm_i);
                o.alu = 5'(alu_base[f3] + ((inst[30] && f3 == 5) ? 1 : 0));
            end
            7'h37: begin o.b = {inst[31:12], 12'h0}; o.alu = 10; o.we = 1; end
            7'h17: begin o.a = pc; o.b = {inst[31:12], 12'h0}; o.we = 1; end
            7'h03: begin o.a = rsv(rs1); o.b = 32'(imm_i); o.re = 1; o.we = 1; end
            7'h23: begin o.a = rsv(rs1); o.b = 32'(imm_s); o.st = rsv(rs2); o.wm = 1; end
            7'h6F: begin o.a = pc; o.b = 4; o.we = 1; end
            default: o.ill = 1;
        endcase
        if (o.rd == 0) o.we = 0;
        return o;
    endfunction

    // {reads rs2, reads rs1}
    function automatic logic [1:0] reads(input logic [31:0] inst);
        case (inst[6:0])
            7'h33:       return (inst[31:25] == 7'h00 || inst[31:25] == 7'h20) ? 2'b11 : 2'b00;
            7'h23:       return 2'b11;
            7'h13, 7'h03: return 2'b01;
            default:     return 2'b00;
        endcase
    endfunction

    // Register still being produced by a load: held at the output, or consumed last cycle.
    function automatic logic busy(input logic [4:0] r);
        if (r == 0) return 1'b0;
        if (m_vld && m_op.re && m_op.rd == r) return 1'b1;
        return (ld_cyc == cyc - 1) && (ld_rd == r);
    endfunction

    task automatic model_cycle();
        op_t d;
        logic [1:0] rm;
        logic haz, rdy, leave;
        d   = ref_dec(in_inst_i, in_pc_i);
        rm  = reads(in_inst_i);
        haz = (rm[0] && busy(in_inst_i[19:15])) || (rm[1] && busy(in_inst_i[24:20]));
        rdy = !haz && !flush_i && (!m_vld || out_ready_i);
        obs_rdy = in_ready_o;
        chk("raddr1", 64'(reg1_raddr_o), 64'(in_inst_i[19:15]));
        chk("raddr2", 64'(reg2_raddr_o), 64'(in_inst_i[24:20]));
        chk("out_valid", 64'(out_valid_o), 64'(m_vld));
        if (m_vld) begin
            chk("illegal", 64'(illegal_o), 64'(m_op.ill));
            chk("reg_we", 64'(reg_we_o), 64'(m_op.we));
            chk("mem_re", 64'(mem_re_o), 64'(m_op.re));
            chk("mem_we", 64'(mem_we_o), 64'(m_op.wm));
            chk("alu_ctrl", 64'(alu_ctrl_o), 64'(m_op.alu));
            if (!m_op.ill) begin
                chk("out_pc", 64'(out_pc_o), 64'(m_op.pc));
                chk("op_a", 64'(op_a_o), 64'(m_op.a));
                chk("op_b", 64'(op_b_o), 64'(m_op.b));
                chk("st_data", 64'(st_data_o), 64'(m_op.st));
                chk("waddr", 64'(reg_waddr_o), 64'(m_op.rd));
            end
        end
        if (!rst) chk("in_ready", 64'(in_ready_o), 64'(rdy));
        if (rst) begin
            m_vld  = 1'b0;
            ld_cyc = -10;
        end else begin
            leave = m_vld && out_ready_i && m_op.re && m_op.rd != 0;
            if (leave) begin ld_cyc = cyc; ld_rd = m_op.rd; end
            if (flush_i) begin
                m_vld = 1'b0; ld_cyc = -10;
            end else if (in_valid_i && rdy) begin
                m_vld = 1'b1; m_op = d;
            end else if (out_ready_i) begin
                m_vld = 1'b0;
            end
        end
        cyc++;
    endtask

    // One clock: apply inputs, check at the falling edge, return 1ns after the rising edge.
    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid_i = v; in_inst_i = inst; in_pc_i = pc; out_ready_i = ordy; flush_i = fl;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd = 5'($urandom_range(0, 3));
        logic [4:0]  r1 = 5'($urandom_range(0, 3));
        logic [4:0]  r2 = 5'($urandom_range(0, 3));
        logic [2:0]  f3 = 3'($urandom);
        logic [11:0] im = 12'($urandom);
        logic [19:0] iu = 20'($urandom);
        case ($urandom_range(0, 8))
            0: return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, r2, r1, f3, rd, 7'h33};
            1: return {im, r1, f3, rd, 7'h13};
            2: return {iu, rd, 7'h37};
            3: return {iu, rd, 7'h17};
            4, 5: return {im, r1, 3'b010, rd, 7'h03};
            6: return {im[11:5], r2, r1, 3'b010, im[4:0], 7'h23};
            7: return {iu, rd, 7'h6F};
            default: return ($urandom_range(0, 1) != 0) ? {im, r1, f3, rd, 7'h7F}
                                                        : {7'h01, r2, r1, f3, rd, 7'h33};
        endcase
    endfunction

    localparam logic [31:0] I_ADDI = 32'hFFB00093;  // addi x1,x0,-5
    localparam logic [31:0] I_LW   = 32'h00012283;  // lw   x5,0(x2)
    localparam logic [31:0] I_ADD  = 32'h00328333;  // add  x6,x5,x3
    localparam logic [31:0] I_SUB  = 32'h409403B3;  // sub  x7,x8,x9
    localparam logic [31:0] I_ADDI2= 32'h00100593;  // addi x11,x0,1
    localparam logic [31:0] I_ILL  = 32'h0000057F;
    localparam logic [31:0] I_MUL  = 32'h022080B3;  // funct7=0x01
    localparam logic [31:0] I_LUI  = 32'h12345537;  // lui  x10,0x12345

    initial begin
        int stalls;
        rf[0] = '0;
        for (int i = 1; i < 32; i++) rf[i] = $urandom | 32'h1;

        // Reset, with in_valid asserted (must be ignored)
        drive(1, I_ADDI, 32'h80, 1, 0);
        drive(1, I_ADDI, 32'h80, 1, 0);
        chk("rst_valid", 64'(out_valid_o), 0);
        chk("rst_op_a", 64'(op_a_o), 0);
        chk("rst_op_b", 64'(op_b_o), 0);
        chk("rst_pc", 64'(out_pc_o), 0);
        chk("rst_alu", 64'(alu_ctrl_o), 0);
        chk("rst_flags", 64'({reg_we_o, mem_re_o, mem_we_o, illegal_o}), 0);
        rst = 1'b0;

        // ADDI x1,x0,-5
        drive(1, I_ADDI, 32'h100, 1, 0);
        chk("rst_first_rdy", 64'(obs_rdy), 1);
        chk("addi_a", 64'(op_a_o), 0);
        chk("addi_b", 64'(op_b_o), 64'h0000_0000_FFFF_FFFB);
        chk("addi_alu", 64'(alu_ctrl_o), 0);
        chk("addi_rd", 64'(reg_waddr_o), 1);
        chk("addi_we", 64'(reg_we_o), 1);
        chk("addi_pc", 64'(out_pc_o), 64'h100);

        // Load-use: two stall cycles, then ADD picks up register-file x5
        drive(1, I_LW, 32'h200, 1, 0);
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, I_ADD, 32'h204, 1, 0);
            if (obs_rdy) break;
            stalls++;
        end
        chk("lu_stalls", 64'(stalls), 2);
        chk("lu_valid", 64'(out_valid_o), 1);
        chk("lu_op_a", 64'(op_a_o), 64'(rf[5]));
        chk("lu_pc", 64'(out_pc_o), 64'h204);

        // SUB held for 3 cycles by back-pressure
        drive(1, I_SUB, 32'h300, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, I_ADDI2, 32'h304, 0, 0);
            chk("hold_rdy", 64'(obs_rdy), 0);
            chk("hold_alu", 64'(alu_ctrl_o), 1);
            chk("hold_pc", 64'(out_pc_o), 64'h300);
            chk("hold_a", 64'(op_a_o), 64'(rf[8]));
        end
        drive(1, I_ADDI2, 32'h304, 1, 0);
        chk("hold_release", 64'(out_pc_o), 64'h304);

        // Flush during the shadow cycle releases the stall
        drive(1, I_LW, 32'h400, 1, 0);
        drive(1, I_ADD, 32'h404, 1, 0);
        drive(1, I_ADD, 32'h404, 1, 1);
        chk("fl_valid", 64'(out_valid_o), 0);
        drive(1, I_ADD, 32'h404, 1, 0);
        chk("fl_rdy", 64'(obs_rdy), 1);
        chk("fl_pc", 64'(out_pc_o), 64'h404);

        // Illegal encodings and LUI
        drive(1, I_ILL, 32'h500, 1, 0);
        chk("ill_flag", 64'(illegal_o), 1);
        chk("ill_flags0", 64'({reg_we_o, mem_re_o, mem_we_o}), 0);
        chk("ill_alu", 64'(alu_ctrl_o), 0);
        drive(1, I_MUL, 32'h504, 1, 0);
        chk("f7_ill", 64'(illegal_o), 1);
        chk("f7_we", 64'(reg_we_o), 0);
        drive(1, I_LUI, 32'h508, 1, 0);
        chk("lui_a", 64'(op_a_o), 0);
        chk("lui_b", 64'(op_b_o), 64'h1234_5000);
        chk("lui_alu", 64'(alu_ctrl_o), 10);

        // Reset in the middle of a load-use stall drops the held load and shadow
        drive(1, I_LW, 32'h600, 1, 0);
        drive(1, I_ADD, 32'h604, 0, 0);
        rst = 1'b1;
        drive(1, I_ADD, 32'h604, 1, 0);
        rst = 1'b0;
        chk("mrst_valid", 64'(out_valid_o), 0);
        drive(1, I_ADD, 32'h604, 1, 0);
        chk("mrst_rdy", 64'(obs_rdy), 1);

`ifdef ID_FWD_EN
        rf[4] = '0;
        fwd_we = 1'b1; fwd_addr = 5'd4; fwd_data = 32'hDEADBEEF;
        drive(1, 32'h004200B3, 32'h700, 1, 0);  // add x1,x4,x4
        chk("fwd_a", 64'(op_a_o), 64'hDEAD_BEEF);
        chk("fwd_b", 64'(op_b_o), 64'hDEAD_BEEF);
        fwd_we = 1'b0;
        rf[4] = 32'h44;
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) rf[$urandom_range(1, 31)] = $urandom;
`ifdef ID_FWD_EN
            fwd_we   = ($urandom_range(0, 1) != 0);
            fwd_addr = 5'($urandom_range(0, 3));
            fwd_data = $urandom;
`endif
            drive($urandom_range(0, 3) != 0, rand_inst(), $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/id_decode_pipe.md
# id_decode_pipe

Parametrised decode stage with an integrated ID/EX output register and valid/ready handshakes on both sides. It decodes RV32I-subset instructions, reads the register file combinationally, builds operands and ALU control, detects load-use hazards and inserts bubbles. It sits between the IF/ID register and the execute stage, replacing the unregistered decode stage.

## Interface
- XLEN, 32, datapath/PC width (32 or 64); immediates sign-extended to XLEN
- RADDR_W, 5, register address width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid_i  in  1  IF/ID holds a valid instruction
- in_ready_o  out  1  stage accepts the instruction this cycle
- in_pc_i  in  XLEN  instruction PC
- in_inst_i  in  32  instruction word
- flush_i  in  1  kill the held and incoming instruction
- reg1_raddr_o / reg2_raddr_o  out  RADDR_W  inst[19:15] / inst[24:20], combinational
- reg1_rdata_i / reg2_rdata_i  in  XLEN  register file read data, same cycle
- out_valid_o  out  1  output register holds a valid op
- out_ready_i  in  1  execute stage consumes the op
- out_pc_o, op_a_o, op_b_o, st_data_o  out  XLEN  PC, ALU operands, store data
- reg_waddr_o  out  RADDR_W  rd
- reg_we_o, mem_re_o, mem_we_o, illegal_o  out  1  each  control flags
- alu_ctrl_o  out  5  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASSB=10
- ex_fwd_we_i, ex_fwd_waddr_i[RADDR_W], ex_fwd_wdata_i[XLEN]  in  forwarding port (only with ID_FWD_EN)

## Operation
- Decoded opcodes: OP (0110011), OP-IMM (0010011), LUI, AUIPC, LOAD, STORE, JAL. Any other opcode, or an OP func7 other than 0x00/0x20: illegal_o=1, reg_we_o=0, mem_re_o=mem_we_o=0, alu_ctrl_o=ADD.
- Operand A: rs1 data (OP, OP-IMM, LOAD, STORE); in_pc_i (AUIPC, JAL); 0 (LUI).
- Operand B: rs2 data (OP); I-imm (OP-IMM, LOAD); S-imm (STORE); U-imm with low 12 bits zero (LUI, AUIPC); 4 (JAL). LUI uses PASSB; LOAD/STORE/AUIPC/JAL use ADD.
- st_data_o = rs2 data for STORE, else 0. reg_we_o=0 for STORE, and also whenever rd=0.
- Shift-immediates take shamt from inst[24:20]. SRAI is selected by inst[30].
- Output register: loads on accept (in_valid_i & in_ready_o). Clears out_valid_o when out_ready_i & out_valid_o and there is no new accept.
- Hazard tracking, two states:
  - LD_NONE to LD_SHADOW when a load (mem_re, rd≠0) leaves the output register. Capture its rd.
  - LD_SHADOW to LD_NONE after exactly one cycle, or on flush.
- Hazard = the incoming instruction reads (per decoded type) a register equal to a non-zero rd of either a valid load held in the output register, or the load captured in LD_SHADOW.
- in_ready_o = !hazard & !flush_i & (!out_valid_o | out_ready_i). A hazard with an empty output register leaves out_valid_o=0, which is the bubble.
- Flush: out_valid_o←0 and state←LD_NONE at the next edge. Takes priority over accept.

## Timing
- One-cycle latency: an op accepted at edge N appears on the outputs after edge N.
- Outputs stay stable while out_valid_o & !out_ready_i.
- Load-use: dependent instruction stalls a minimum of 2 cycles after the load is accepted, i.e. the load leaves plus one shadow cycle. 1 bubble is seen at execute.
- Back-to-back independent ops: 1 per cycle with out_ready_i held high.
- Reset: out_valid_o=0, all data outputs 0, alu_ctrl_o=0, flags 0, state LD_NONE. in_ready_o=1 the first cycle after reset if in_valid_i and no hazard.
- Reset mid-stall drops the held op and the shadow state. in_valid_i with rst high is ignored.

## Configuration
- ID_FWD_EN defined: when ex_fwd_we_i & ex_fwd_waddr_i≠0 & ex_fwd_waddr_i equals rs1/rs2, the corresponding operand/st_data uses ex_fwd_wdata_i instead of the register file data. Load-use stalls remain.
- ID_FWD_EN undefined: forwarding ports are absent and operands come only from the register file.

## Test plan
- ADDI x1,x0,-5 (0xFFB00093), pc=0x100 -> next cycle op_a=0, op_b=0xFFFFFFFB, alu_ctrl=ADD, reg_waddr=1, reg_we=1, out_pc=0x100.
- LW x5,0(x2) then ADD x6,x5,x3 held valid with out_ready=1 -> in_ready low for 2 cycles, one out_valid=0 bubble, then ADD issues with op_a = register file x5.
- SUB x7,x8,x9 with out_ready=0 for 3 cycles -> outputs held stable, in_ready=0, op issued once when out_ready rises, alu_ctrl=1.
- Flush asserted while an LD_SHADOW stall is pending -> out_valid=0 next cycle, stall released, next instruction accepted the following cycle.
- Opcode 0x7F -> illegal_o=1, reg_we=0, mem flags 0. LUI x10,0x12345 -> op_a=0, op_b=0x12345000, alu_ctrl=10.
- ID_FWD_EN set: ex_fwd x4=0xDEADBEEF while the register file returns 0 for x4, with ADD x1,x4,x4 -> op_a=op_b=0xDEADBEEF.
